adder_vector_checker: RTL and testbench

Self-checking stimulus/response stage for the adder exercises: drives exhaustive operand pairs into an adder DUT and consumes its {carry,sum} result.
Steps every operand combination under a small FSM, waits a programmable settle time, and compares the DUT output against a locally computed reference.
Reports error count, first failing vector, and pass/done flags.
Sits directly upstream (a,b) and downstream ({c,s}) of the adder, replacing the hand-written initial-block stimulus.

---
 rtl/adder_vector_checker_pkg.sv | 12 +
 rtl/adder_vector_checker_vec_counter.sv | 29 ++
 rtl/adder_vector_checker.sv | 131 +++++++++++++
 tb/tb_adder_vector_checker.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/adder_vector_checker_pkg.sv
// Shared definitions for the adder vector checker: sweep FSM state encoding.
package adder_vector_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/adder_vector_checker_vec_counter.sv
// Operand index for the exhaustive sweep: clear, increment and last-vector flag.
module vec_counter #(
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)      idx_d = '0;
    else if (inc_i) idx_d = idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

  assign idx_o  = idx_q;
  assign last_o = &idx_q;

endmodule

// File: rtl/adder_vector_checker.sv
// Exhaustive stimulus/response checker for a W-bit adder: drives every {a,b}
// pair, waits SETTLE cycles, and compares {carry,sum} against a local reference.
module adder_vector_checker
  import adder_vector_checker_pkg::*;
#(
  parameter int W      = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  input  logic [W:0]     res_in,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [ERR_W-1:0] err_count,
  output logic           first_fail_valid,
  output logic [2*W-1:0] first_fail_vec
);

  localparam int IW = 2 * W;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             ffv_q, ffv_d;
  logic [IW-1:0]    ffvec_q, ffvec_d;

  logic             idx_clr, idx_inc, idx_last;
  logic [IW-1:0]    idx;
  logic [W:0]       ref_sum;
  logic             mismatch;

  vec_counter #(.IW(IW)) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (idx_clr),
    .inc_i  (idx_inc),
    .idx_o  (idx),
    .last_o (idx_last)
  );

  assign ref_sum  = {1'b0, a_q} + {1'b0, b_q};
  // Case inequality so that any X/Z on the DUT result counts as a failure.
  assign mismatch = (res_in !== ref_sum);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          idx_clr = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        a_d     = idx[IW-1:W];
        b_d     = idx[W-1:0];
        cnt_d   = CW'(SETTLE - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = {a_q, b_q};
          end
        end
        // Terminal test precedes the increment so the index never wraps.
        if (idx_last) begin
          state_d = S_DONE;
        end else begin
          idx_inc = 1'b1;
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign a_out            = a_q;
  assign b_out            = b_q;
  assign busy             = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done             = (state_q == S_DONE);
  assign pass             = done && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_adder_vector_checker.sv
// Directed bench: a W=1 checker against a modelled half adder with fault modes,
// and a W=4 checker against an adder whose output is stuck at zero.
module tb_adder_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0;
  int         checks = 0, errors = 0;
  int         mode = 0;  // 0 good, 1 carry stuck at 0, 2 sum/carry swapped

  logic [0:0] a1, b1;
  logic [1:0] res1;
  logic       busy1, done1, pass1, ffv1;
  logic [7:0] err1;
  logic [1:0] ffvec1;

  logic [3:0] a4, b4;
  logic [4:0] res4;
  logic       busy4, done4, pass4, ffv4;
  logic [3:0] err4;
  logic [7:0] ffvec4;

  always_comb begin
    case (mode)
      1:       res1 = {1'b0, a1 ^ b1};
      2:       res1 = {a1 ^ b1, a1 & b1};
      default: res1 = {a1 & b1, a1 ^ b1};
    endcase
  end
  assign res4 = '0;

  adder_vector_checker #(.W(1), .SETTLE(1), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .res_in(res1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  adder_vector_checker #(.W(4), .SETTLE(1), .ERR_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a_out(a4), .b_out(b4), .res_in(res4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_fail_valid(ffv4), .first_fail_vec(ffvec4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start across one rising edge; returns #1 after that edge.
  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((which == 4) ? !done4 : !done1) && n < limit);
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a1", a1, 0);       chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0); chk("rst_pass1", pass1, 0);
    chk("rst_err1", err1, 0);   chk("rst_ffv1", ffv1, 0);
    chk("rst_ffvec1", ffvec1, 0);
    chk("rst_a4b4", {a4, b4}, 0); chk("rst_done4", done4, 0);
    rst = 1'b0;

    // Good half adder: detailed cycle trace of a full sweep.
    mode = 0;
    pulse(1);
    chk("good_busy_e0", busy1, 1);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if ((k - 1) % 3 == 0) chk($sformatf("good_vec_e%0d", k), {a1, b1}, (k - 1) / 3);
      if (k < 12) begin
        chk($sformatf("good_busy_e%0d", k), busy1, 1);
        chk($sformatf("good_done_e%0d", k), done1, 0);
      end
    end
    chk("good_done", done1, 1); chk("good_busy_end", busy1, 0);
    chk("good_pass", pass1, 1); chk("good_err", err1, 0);
    chk("good_ffv", ffv1, 0);   chk("good_hold_vec", {a1, b1}, 2'b11);

    // Carry stuck at 0: only 1+1 fails.
    mode = 1;
    pulse(1);
    chk("cs_done_cleared", done1, 0);
    wait_done(1, 100, n);
    chk("cs_edges", n, 12);
    chk("cs_err", err1, 1); chk("cs_ffv", ffv1, 1);
    chk("cs_ffvec", ffvec1, 2'b11); chk("cs_pass", pass1, 0);

    // Sum and carry swapped: 01, 10, 11 fail.
    mode = 2;
    pulse(1);
    chk("sw_err_cleared", err1, 0); chk("sw_ffv_cleared", ffv1, 0);
    wait_done(1, 100, n);
    chk("sw_edges", n, 12);
    chk("sw_err", err1, 3); chk("sw_ffvec", ffvec1, 2'b01); chk("sw_pass", pass1, 0);

    // Reset during the second vector, then a clean sweep.
    mode = 0;
    pulse(1);
    repeat (4) @(posedge clk);
    #1;
    chk("rm_vec_before", {a1, b1}, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rm_a1b1", {a1, b1}, 0); chk("rm_busy", busy1, 0);
    chk("rm_done", done1, 0);    chk("rm_err", err1, 0);
    chk("rm_ffv", ffv1, 0);      chk("rm_ffvec", ffvec1, 0);
    pulse(1);
    wait_done(1, 100, n);
    chk("rm_edges", n, 12); chk("rm_pass", pass1, 1); chk("rm_err_end", err1, 0);

    // start while busy is ignored: done timing unchanged.
    mode = 1;
    pulse(1);
    repeat (4) @(posedge clk);
    pulse(1);
    chk("mid_busy", busy1, 1);
    wait_done(1, 100, n);
    chk("mid_edges", n, 7);
    chk("mid_err", err1, 1); chk("mid_ffvec", ffvec1, 2'b11);

    // start after done clears results and runs a fresh sweep.
    mode = 0;
    pulse(1);
    chk("pd_done", done1, 0); chk("pd_err", err1, 0);
    chk("pd_ffv", ffv1, 0);   chk("pd_ffvec", ffvec1, 0);
    chk("pd_busy", busy1, 1);
    wait_done(1, 100, n);
    chk("pd_edges", n, 12); chk("pd_pass", pass1, 1);

    // W=4 with output stuck at zero: error counter saturates.
    pulse(4);
    wait_done(4, 2000, n);
    chk("w4_edges", n, 768);
    chk("w4_done", done4, 1); chk("w4_err", err4, 4'hF);
    chk("w4_ffv", ffv4, 1);   chk("w4_ffvec", ffvec4, 8'h01);
    chk("w4_pass", pass4, 0); chk("w4_hold_vec", {a4, b4}, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
